// File: rtl/cpu19_pkg.sv
// cpu19_pkg: shared types and constants for the cpu19 decode/execute boundary
// Contents: SP sequencing FSM state enum, register address width, SP opcode.
package cpu19_pkg;
  localparam int REG_ADDR_W = 4;
  localparam logic [6:0] SP_OPCODE = 7'b0001011;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SP_BUSY = 2'd1,
    SP_DONE = 2'd2
  } sp_state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard between decode and the ID/IE register
// Ports: rs1_addr/rs2_addr, rs1_used/rs2_used (decode sources); wb_addr, mem_rd,
// reg_wr, start (ID/IE register); lu (hazard present this cycle).
module hazard_detect
  import cpu19_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  mem_rd,
  input  logic                  reg_wr,
  input  logic                  start,
  output logic                  lu
);
  assign lu = mem_rd & reg_wr & ~start &
              ((rs1_used & (rs1_addr == wb_addr)) | (rs2_used & (rs2_addr == wb_addr)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall and SP (crypto) sequencing controller
// Ports: clk_in, rst_in (async, active-low); id_* decode sources; ie_* ID/IE
// register fields; sp_done accelerator pulse; stall_pc, stall_ifid, bubble_idie
// pipeline controls; sp_busy, sp_wb_en SP status; sp_err sticky timeout;
// stall_cnt saturating count of PC-stall cycles.
module pipe_hazard_ctrl
  import cpu19_pkg::*;
#(
  parameter int SP_TIMEOUT = 200,
  parameter int TO_W       = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ie_wb_addr,
  input  logic                  ie_mem_rd,
  input  logic                  ie_reg_wr,
  input  logic                  ie_start,
  input  logic                  sp_done,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  bubble_idie,
  output logic                  sp_busy,
  output logic                  sp_wb_en,
  output logic                  sp_err,
  output logic [CNT_W-1:0]      stall_cnt
);
  sp_state_e       state, state_nx;
  logic [TO_W-1:0] to_cnt;
  logic            lu, stall, set_err;
  hazard_detect u_hd (
    .rs1_addr(id_rs1_addr),
    .rs2_addr(id_rs2_addr),
    .rs1_used(id_rs1_used),
    .rs2_used(id_rs2_used),
    .wb_addr (ie_wb_addr),
    .mem_rd  (ie_mem_rd),
    .reg_wr  (ie_reg_wr),
    .start   (ie_start),
    .lu      (lu)
  );
  // lu is gated by reset so stray hazard inputs cannot stall during reset
  assign stall       = (state == IDLE) ? (lu & rst_in) : 1'b1;
  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idie = stall;
  assign sp_busy     = state != IDLE;
  assign sp_wb_en    = state == SP_DONE;
  always_comb begin
    state_nx = state;
    set_err  = 1'b0;
    case (state)
      IDLE:    state_nx = ie_start ? SP_BUSY : IDLE;
      SP_BUSY: begin
        // completion wins over timeout in the same cycle
        if (sp_done) state_nx = SP_DONE;
        else if (to_cnt == TO_W'(SP_TIMEOUT - 1)) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      to_cnt    <= '0;
      sp_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nx;
      to_cnt <= (state == SP_BUSY) ? to_cnt + 1'b1 : '0;
      if (set_err) sp_err <= 1'b1;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
